// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// The arbiter lets the program loader and the CPU output FIFO take turns on one sender.
package uart_pkg;

    localparam int BYTE_W = 8;

    // Boot handshake bytes that the loader sends.
    localparam logic [BYTE_W-1:0] LDR_READY = 8'h99;
    localparam logic [BYTE_W-1:0] LDR_DONE  = 8'haa;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GUARD,
        ARB_DRAIN
    } arb_state_t;

    typedef enum logic {
        SRC_CPU,
        SRC_LDR
    } arb_src_t;

    // The loader normally wins. After a loader byte, a waiting FIFO byte goes first,
    // so the two sources alternate and neither can starve.
    function automatic arb_src_t pick_source(
        input logic ldr_req,
        input logic fifo_empty,
        input logic last_ldr
    );
        if (!fifo_empty && (last_ldr || !ldr_req)) begin
            return SRC_CPU;
        end
        return SRC_LDR;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Interface for the loader, CPU and sender connections of the UART transmit arbiter.
// The slave modport is the arbiter's side of the interface.
interface uart_tx_arbiter_if #(
    parameter int FIFO_DEPTH = 16
);
    import uart_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          ldr_req;
    byte_t         ldr_data;
    logic          ldr_grant;
    logic          cpu_valid;
    byte_t         cpu_data;
    logic          cpu_ready;
    logic [CW-1:0] fifo_count;
    logic          tx_busy;
    logic          tx_start;
    byte_t         sdata;

    modport master (
        output ldr_req,
        output ldr_data,
        output cpu_valid,
        output cpu_data,
        output tx_busy,
        input  ldr_grant,
        input  cpu_ready,
        input  fifo_count,
        input  tx_start,
        input  sdata
    );

    modport slave (
        input  ldr_req,
        input  ldr_data,
        input  cpu_valid,
        input  cpu_data,
        input  tx_busy,
        output ldr_grant,
        output cpu_ready,
        output fifo_count,
        output tx_start,
        output sdata
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO built on a RAM array. The head byte is held in a register so that the
// arbiter can load it into sdata on the same edge that pops it.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses the push even if a pop happens on the same edge.
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // The RAM read is registered, so a byte written into the slot that becomes the
        // head must bypass the array.
        if (do_push && (wr_ptr_q == rd_ptr_d)) begin
            head_d = push_data;
        end else begin
            head_d = mem[rd_ptr_d];
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign head  = head_q;
    assign count = count_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART sender between the program loader and the buffered CPU output bytes.
// The loader and CPU sources take turns on the sender, and all sender-facing outputs are registered.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clock,
    input  logic               reset,
    uart_tx_arbiter_if.slave   bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    arb_state_t    state_q, state_d;
    byte_t         sdata_q, sdata_d;
    logic          tx_start_q, tx_start_d;
    logic          ldr_grant_q, ldr_grant_d;
    logic          last_ldr_q, last_ldr_d;

    byte_t         fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [CW-1:0] fifo_count;
    arb_src_t      src;

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (bus.cpu_valid),
        .push_data (bus.cpu_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign src = pick_source(bus.ldr_req, fifo_empty, last_ldr_q);

    always_comb begin
        state_d     = state_q;
        sdata_d     = sdata_q;
        tx_start_d  = 1'b0;
        ldr_grant_d = 1'b0;
        last_ldr_d  = last_ldr_q;
        fifo_pop    = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                // IDLE is also the state after reset, so a byte the sender is still
                // shifting out is allowed to finish before the next start.
                if (!bus.tx_busy && (bus.ldr_req || !fifo_empty)) begin
                    tx_start_d  = 1'b1;
                    sdata_d     = (src == SRC_CPU) ? fifo_head : bus.ldr_data;
                    fifo_pop    = (src == SRC_CPU);
                    ldr_grant_d = (src == SRC_LDR);
                    last_ldr_d  = (src == SRC_LDR);
                    state_d     = ARB_GUARD;
                end
            end
            // The sender may raise tx_busy one cycle late, so tx_busy is ignored here.
            ARB_GUARD: state_d = ARB_DRAIN;
            ARB_DRAIN: begin
                if (!bus.tx_busy) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            sdata_q     <= '0;
            tx_start_q  <= 1'b0;
            ldr_grant_q <= 1'b0;
            last_ldr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sdata_q     <= sdata_d;
            tx_start_q  <= tx_start_d;
            ldr_grant_q <= ldr_grant_d;
            last_ldr_q  <= last_ldr_d;
        end
    end

    assign bus.tx_start   = tx_start_q;
    assign bus.sdata      = sdata_q;
    assign bus.ldr_grant  = ldr_grant_q;
    assign bus.cpu_ready  = !fifo_full;
    assign bus.fifo_count = fifo_count;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised and directed bench for uart_tx_arbiter. A queue-based reference model predicts
// every start, the byte sent, the grants and the FIFO occupancy.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int DEPTH = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    uart_tx_arbiter_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_tx_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int    checks = 0;
    int    errors = 0;

    // reference model state
    byte_t mq[$];
    byte_t sent_log[$];
    bit    m_last_ldr  = 1'b0;
    bit    m_released  = 1'b1;
    int    m_since     = 0;
    byte_t m_sdata     = 8'h00;

    // sender and loader behaviour
    int    busy_len    = 4;
    int    busy_left   = 0;
    bit    stuck_busy  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: capture the inputs the DUT will sample, advance, compare against the model,
    // then let the sender and loader react to what came out.
    task automatic cycle();
        bit    p_rst  = reset;
        bit    p_req  = bus.ldr_req;
        bit    p_val  = bus.cpu_valid;
        bit    p_busy = bus.tx_busy;
        byte_t p_ld   = bus.ldr_data;
        byte_t p_cd   = bus.cpu_data;
        int    pre_size = mq.size();
        bit    exp_start;
        bit    src_ldr;
        byte_t exp_byte;
        @(posedge clock);
        #1;
        if (p_rst) begin
            mq.delete();
            m_last_ldr = 1'b0;
            m_released = 1'b1;
            m_since    = 0;
            m_sdata    = 8'h00;
            check_eq("rst_start", bus.tx_start, 0);
            check_eq("rst_grant", bus.ldr_grant, 0);
            check_eq("rst_sdata", bus.sdata, 0);
            check_eq("rst_count", bus.fifo_count, 0);
            check_eq("rst_ready", bus.cpu_ready, 1);
        end else begin
            exp_start = m_released && !p_busy && (p_req || pre_size > 0);
            src_ldr   = p_req && !(m_last_ldr && pre_size > 0);
            check_eq("start", bus.tx_start, exp_start);
            if (exp_start) begin
                exp_byte = src_ldr ? p_ld : mq[0];
                m_sdata  = exp_byte;
                check_eq("grant", bus.ldr_grant, src_ldr);
                if (!src_ldr) begin
                    void'(mq.pop_front());
                end
                m_last_ldr = src_ldr;
                m_released = 1'b0;
                m_since    = 0;
                sent_log.push_back(exp_byte);
                $display("tx byte=%02h src=%s queued=%0d t=%0t", exp_byte,
                         src_ldr ? "ldr" : "cpu", mq.size(), $time);
            end else begin
                check_eq("grant", bus.ldr_grant, 0);
                m_since++;
                if (!m_released && m_since >= 2 && !p_busy) begin
                    m_released = 1'b1;
                end
            end
            check_eq("sdata", bus.sdata, m_sdata);
            if (p_val && pre_size < DEPTH) begin
                mq.push_back(p_cd);
            end
            check_eq("count", bus.fifo_count, mq.size());
            check_eq("ready", bus.cpu_ready, mq.size() < DEPTH);
        end
        if (bus.tx_start) begin
            busy_left = busy_len;
        end else if (busy_left > 0) begin
            busy_left--;
        end
        bus.tx_busy = stuck_busy || (busy_left > 0);
        if (bus.ldr_grant) begin
            bus.ldr_req = 1'b0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            cycle();
        end
    endtask

    initial begin
        int    ldr_left;
        int    sent_before;
        bit    seen;
        byte_t ref_byte;

        bus.ldr_req   = 1'b0;
        bus.ldr_data  = 8'h00;
        bus.cpu_valid = 1'b0;
        bus.cpu_data  = 8'h00;
        bus.tx_busy   = 1'b0;
        reset         = 1'b1;
        run(3);
        reset = 1'b0;
        run(2);

        // loader handshake byte on an idle bus
        sent_log.delete();
        seen          = 1'b0;
        busy_len      = 4;
        bus.ldr_data  = LDR_READY;
        bus.ldr_req   = 1'b1;
        cycle();
        check_eq("t1_grant", bus.ldr_grant, 1);
        check_eq("t1_start", bus.tx_start, 1);
        check_eq("t1_sdata", bus.sdata, LDR_READY);
        cycle();
        check_eq("t1_grant_pulse", bus.ldr_grant, 0);
        check_eq("t1_start_pulse", bus.tx_start, 0);
        run(12);

        // three CPU bytes back to back, slow sender
        sent_log.delete();
        busy_len = 10;
        for (int i = 0; i < 3; i++) begin
            bus.cpu_valid = 1'b1;
            bus.cpu_data  = 8'h41 + 8'(i);
            cycle();
        end
        bus.cpu_valid = 1'b0;
        run(60);
        check_eq("t2_n", sent_log.size(), 3);
        for (int i = 0; i < 3 && i < sent_log.size(); i++) begin
            check_eq("t2_order", sent_log[i], 8'h41 + 8'(i));
        end

        // fill the FIFO while the sender is stuck busy; the 17th byte is refused
        sent_log.delete();
        stuck_busy  = 1'b1;
        bus.tx_busy = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            bus.cpu_valid = 1'b1;
            bus.cpu_data  = 8'h60 + 8'(i);
            cycle();
        end
        bus.cpu_valid = 1'b0;
        cycle();
        check_eq("t3_count", bus.fifo_count, DEPTH);
        check_eq("t3_ready", bus.cpu_ready, 0);
        stuck_busy = 1'b0;
        busy_len   = 2;
        run(120);
        check_eq("t3_n", sent_log.size(), DEPTH);
        for (int i = 0; i < DEPTH && i < sent_log.size(); i++) begin
            check_eq("t3_data", sent_log[i], 8'h60 + 8'(i));
        end

        // loader and FIFO alternate
        sent_log.delete();
        stuck_busy  = 1'b1;
        bus.tx_busy = 1'b1;
        bus.cpu_valid = 1'b1;
        bus.cpu_data  = 8'h10;
        cycle();
        bus.cpu_data  = 8'h11;
        cycle();
        bus.cpu_valid = 1'b0;
        bus.ldr_data  = LDR_DONE;
        bus.ldr_req   = 1'b1;
        ldr_left      = 1;
        stuck_busy    = 1'b0;
        busy_len      = 3;
        for (int i = 0; i < 80; i++) begin
            cycle();
            if (!bus.ldr_req && ldr_left > 0) begin
                bus.ldr_req = 1'b1;
                ldr_left--;
            end
        end
        check_eq("t4_n", sent_log.size(), 4);
        for (int i = 0; i < 4 && i < sent_log.size(); i++) begin
            ref_byte = (i % 2 == 0) ? LDR_DONE : (8'h10 + 8'(i / 2));
            check_eq("t4_order", sent_log[i], ref_byte);
        end

        // reset while draining a byte with the sender still busy
        busy_len = 8;
        for (int i = 0; i < 3; i++) begin
            bus.cpu_valid = 1'b1;
            bus.cpu_data  = 8'h20 + 8'(i);
            cycle();
        end
        bus.cpu_valid = 1'b0;
        run(4);
        check_eq("t5_busy_before", bus.tx_busy, 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check_eq("t5_count", bus.fifo_count, 0);
        sent_before = sent_log.size();
        run(15);
        check_eq("t5_nostart", sent_log.size(), sent_before);

        // push and pop on the same edge at count 5
        busy_len    = 3;
        stuck_busy  = 1'b1;
        bus.tx_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.cpu_valid = 1'b1;
            bus.cpu_data  = 8'h30 + 8'(i);
            cycle();
        end
        bus.cpu_valid = 1'b0;
        stuck_busy    = 1'b0;
        cycle();
        bus.cpu_valid = 1'b1;
        bus.cpu_data  = 8'h35;
        cycle();
        bus.cpu_valid = 1'b0;
        check_eq("t6_start", bus.tx_start, 1);
        check_eq("t6_sdata", bus.sdata, 8'h30);
        check_eq("t6_count", bus.fifo_count, 5);
        run(40);

        // random traffic from both sources; many bytes wrap the FIFO pointers
        for (int i = 0; i < 2500; i++) begin
            busy_len      = int'($urandom_range(1, 6));
            bus.cpu_valid = ($urandom_range(0, 3) == 0);
            bus.cpu_data  = byte_t'($urandom);
            if (!bus.ldr_req && $urandom_range(0, 15) == 0) begin
                bus.ldr_req  = 1'b1;
                bus.ldr_data = byte_t'($urandom);
            end else if (bus.ldr_req && $urandom_range(0, 40) == 0) begin
                bus.ldr_req = 1'b0;
            end
            cycle();
        end
        bus.cpu_valid = 1'b0;
        bus.ldr_req   = 1'b0;
        run(200);
        check_eq("final_count", bus.fifo_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
